// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
package mem_access_unit_pkg;

    // Memory access sequencer states.
    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_BUSY  = 2'd1,
        MEM_DONE  = 2'd2,
        MEM_FAULT = 2'd3
    } mem_st_e;

    // Word accesses only: both low address bits must be zero.
    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ADDR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_timeout_ctr.sv
// Saturating BUSY-cycle counter; flags the last cycle allowed before a bus timeout.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    // Count enabled cycles, clearing on request and holding at TIMEOUT so it never wraps.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == CNT_LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Converts the controller's single-cycle memory intent into a req/ack bus
// transaction, stalls the controller until it completes, and owns the
// instruction and memory data registers.
//
// state     | meaning
// ----------+------------------------------------------------------------
// MEM_IDLE  | waiting for req_valid; stall follows req_valid directly
// MEM_BUSY  | bus_req asserted, waiting for bus_ack or timeout
// MEM_DONE  | one-cycle done pulse, controller advances on this edge
// MEM_FAULT | misalign, bus error or timeout; sticky until reset
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              i_or_d,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [DATA_W-1:0] bus_rdata
);

    mem_st_e           state;
    mem_st_e           state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              sel_q;
    logic [ADDR_W-1:0] req_addr;
    logic              accept;
    logic              capture;
    logic              cnt_clr;
    logic              cnt_en;
    logic              expired;

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    // State register, request latches and the instruction / data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MEM_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            instr   <= '0;
            mdr     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= wdata;
                we_q    <= req_write;
                sel_q   <= i_or_d;
            end
            if (capture) begin
                if (sel_q) begin
                    mdr <= bus_rdata;
                end else begin
                    instr <= bus_rdata;
                end
            end
        end
    end

    // Next-state and output decode; stall in IDLE is combinational so the
    // controller holds in the same cycle it raises its request.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        bus_req    = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        req_addr   = i_or_d ? alu_out : pc;
        unique case (state)
            MEM_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = is_misaligned(req_addr[1:0]) ? MEM_FAULT : MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                cnt_en  = 1'b1;
                if (bus_ack) begin
                    capture    = !bus_err && !we_q;
                    state_next = bus_err ? MEM_FAULT : MEM_DONE;
                end else if (expired) begin
                    state_next = MEM_FAULT;
                end
            end
            MEM_DONE: begin
                done       = 1'b1;
                state_next = MEM_IDLE;
            end
            MEM_FAULT: begin
                fault = 1'b1;
                stall = 1'b1;
            end
            default: state_next = MEM_IDLE;
        endcase
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = (state == MEM_BUSY) && we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: stimulus pushes expected completions (done or fault, with
// instr/mdr contents) into a scoreboard; a monitor pops and compares.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic        i_or_d = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] alu_out = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, fault;
    logic [31:0] instr, mdr;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .i_or_d(i_or_d), .pc(pc), .alu_out(alu_out), .wdata(wdata),
        .stall(stall), .done(done), .fault(fault), .instr(instr), .mdr(mdr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_fault;
        logic [31:0] instr;
        logic [31:0] mdr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          tx_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_mdr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic f);
        exp_t e;
        e.is_fault = f;
        e.instr    = m_instr;
        e.mdr      = m_mdr;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per done pulse or fault rising edge.
    initial begin
        logic prev_req = 1'b0;
        logic prev_fault = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req   = 1'b0;
                prev_fault = 1'b0;
            end else begin
                if (bus_req && !prev_req) tx_cnt++;
                if (done) done_cnt++;
                if (done || (fault && !prev_fault)) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_event", 32'(done), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("sb_kind_fault", 32'(fault), 32'(e.is_fault));
                        chk("sb_instr", instr, e.instr);
                        chk("sb_mdr", mdr, e.mdr);
                    end
                end
                prev_req   = bus_req;
                prev_fault = fault;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        step();
        step();
        reset   = 1'b0;
        m_instr = '0;
        m_mdr   = '0;
    endtask

    // One access; ack_at = BUSY cycle carrying bus_ack (0 = never, expect timeout).
    task automatic do_access(input logic wr, input logic sel, input logic [31:0] a_pc,
                             input logic [31:0] a_alu, input logic [31:0] wd,
                             input int ack_at, input logic err, input logic [31:0] rd,
                             input logic hold);
        logic [31:0] exp_addr;
        int          stall_n;
        int          busy_n;
        logic        at_neg;
        exp_addr  = sel ? a_alu : a_pc;
        stall_n   = 0;
        busy_n    = 0;
        at_neg    = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        i_or_d    = sel;
        pc        = a_pc;
        alu_out   = a_alu;
        wdata     = wd;
        @(negedge clk);
        chk("idle_bus_req", 32'(bus_req), 32'(0));
        chk("idle_done", 32'(done), 32'(0));
        if (stall) stall_n++;
        step();
        if (!hold) req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == ack_at) begin
                bus_ack   = 1'b1;
                bus_err   = err;
                bus_rdata = rd;
            end
            @(negedge clk);
            if (!bus_req) begin
                at_neg = 1'b1;
                break;
            end
            busy_n++;
            if (stall) stall_n++;
            chk("busy_addr", bus_addr, exp_addr);
            chk("busy_we", 32'(bus_we), 32'(wr));
            if (wr) chk("busy_wdata", bus_wdata, wd);
            step();
            bus_ack = 1'b0;
            bus_err = 1'b0;
            if (i == ack_at) break;
        end
        if (!at_neg) @(negedge clk);
        chk("busy_cycles", busy_n, (ack_at > 0) ? ack_at : TO);
        if (ack_at > 0 && !err) begin
            chk("done_pulse", 32'(done), 32'(1));
            chk("done_stall", 32'(stall), 32'(0));
            chk("done_bus_req", 32'(bus_req), 32'(0));
            chk("stall_cycles", stall_n, 1 + ack_at);
        end else begin
            chk("fault_flag", 32'(fault), 32'(1));
            chk("fault_stall", 32'(stall), 32'(1));
            chk("fault_bus_req", 32'(bus_req), 32'(0));
            chk("fault_no_done", 32'(done), 32'(0));
        end
        step();
    endtask

    initial begin
        int tx0;
        int d0;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_fault", 32'(fault), 32'(0));
        chk("rst_bus_req", 32'(bus_req), 32'(0));
        chk("rst_bus_we", 32'(bus_we), 32'(0));
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        step();

        // Fetch, ack on 3rd BUSY cycle
        m_instr = 32'h2008_0005;
        push_exp(1'b0);
        do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0000_0999, 32'h0, 3, 1'b0, 32'h2008_0005, 1'b0);

        // Store, ack in first BUSY cycle; nothing captured
        push_exp(1'b0);
        do_access(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0044, 32'hDEAD_BEEF, 1, 1'b0, 32'h7777_7777, 1'b0);

        // Load into mdr
        m_mdr = 32'hCAFE_0001;
        push_exp(1'b0);
        do_access(1'b0, 1'b1, 32'h0, 32'h0000_0080, 32'h0, 2, 1'b0, 32'hCAFE_0001, 1'b0);

        // Bus error: mdr keeps previous value
        push_exp(1'b1);
        do_access(1'b0, 1'b1, 32'h0, 32'h0000_0084, 32'h0, 1, 1'b1, 32'h0000_1234, 1'b0);
        @(negedge clk);
        chk("err_mdr_hold", mdr, 32'hCAFE_0001);
        chk("err_fault_sticky", 32'(fault), 32'(1));
        do_reset();

        // Misaligned load never reaches the bus
        push_exp(1'b1);
        req_valid = 1'b1;
        req_write = 1'b0;
        i_or_d    = 1'b1;
        alu_out   = 32'h0000_0046;
        @(negedge clk);
        chk("mis_stall_req", 32'(stall), 32'(1));
        chk("mis_bus_req0", 32'(bus_req), 32'(0));
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_fault", 32'(fault), 32'(1));
            chk("mis_stall", 32'(stall), 32'(1));
            chk("mis_bus_req", 32'(bus_req), 32'(0));
            step();
        end
        do_reset();

        // Timeout after exactly TO BUSY cycles, late ack ignored
        push_exp(1'b1);
        tx0 = tx_cnt;
        do_access(1'b0, 1'b1, 32'h0, 32'h0000_0200, 32'h0, 0, 1'b0, 32'h0, 1'b0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("to_late_fault", 32'(fault), 32'(1));
        chk("to_late_bus_req", 32'(bus_req), 32'(0));
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("to_late_mdr", mdr, 32'h0);
        chk("to_late_instr", instr, 32'h0);
        chk("to_tx_count", tx_cnt - tx0, 1);
        do_reset();

        // Reset during 2nd BUSY cycle, then late ack in IDLE
        req_valid = 1'b1;
        i_or_d    = 1'b1;
        req_write = 1'b1;
        alu_out   = 32'h0000_0300;
        wdata     = 32'h1111_2222;
        step();
        req_valid = 1'b0;
        step();
        @(negedge clk);
        chk("midbusy_req", 32'(bus_req), 32'(1));
        reset = 1'b1;
        step();
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("mrst_bus_req", 32'(bus_req), 32'(0));
        chk("mrst_bus_we", 32'(bus_we), 32'(0));
        chk("mrst_bus_addr", bus_addr, 32'h0);
        chk("mrst_bus_wdata", bus_wdata, 32'h0);
        chk("mrst_stall", 32'(stall), 32'(0));
        chk("mrst_fault", 32'(fault), 32'(0));
        step();
        bus_ack = 1'b0;
        @(negedge clk);
        chk("mrst_late_mdr", mdr, 32'h0);
        chk("mrst_late_instr", instr, 32'h0);
        chk("mrst_late_done", 32'(done), 32'(0));
        step();

        // Back-to-back load then store with req_valid held through DONE
        tx0 = tx_cnt;
        d0  = done_cnt;
        m_mdr = 32'hA5A5_0001;
        push_exp(1'b0);
        do_access(1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'h0, 1, 1'b0, 32'hA5A5_0001, 1'b1);
        push_exp(1'b0);
        do_access(1'b1, 1'b1, 32'h0, 32'h0000_0104, 32'h0BAD_F00D, 2, 1'b0, 32'h9999_9999, 1'b1);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_quiet_req", 32'(bus_req), 32'(0));
            chk("b2b_quiet_done", 32'(done), 32'(0));
            step();
        end
        chk("b2b_tx_count", tx_cnt - tx0, 2);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
